// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Pipeline hold/flush arbiter for the IF/ID and ID/EX registers.
//             Optional perf counters are enabled by PIPE_HAZARD_PERF_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES      = 2,
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        int_assert_i,
    input  logic [31:0] int_addr_i,
    input  logic        hold_ex_i,
    input  logic        hold_bus_i,
    input  logic        load_use_i,
    output logic [2:0]  hold_flag_o,
    output logic        flush_idex_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        busy_o
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] perf_flush_cnt_o,
    output logic [31:0] perf_stall_cnt_o
`endif
);

    localparam logic [2:0] c_HOLD_NONE   = 3'd0;
    localparam logic [2:0] c_HOLD_IF     = 3'd2;
    localparam logic [2:0] c_HOLD_ID     = 3'd3;
    localparam logic [2:0] c_FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);
    localparam logic [2:0] c_LDSTL_INIT  = 3'(LOAD_STALL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_LDSTALL = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_nxt;
    logic       w_redirect;
    logic       w_hold_req;

    assign w_redirect = int_assert_i | jump_flag_i;
    assign w_hold_req = hold_ex_i | hold_bus_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs are the max of the registered state's level and the same-cycle
    // request level; everything collapses to zero while reset is held.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        hold_flag_o  = c_HOLD_NONE;
        flush_idex_o = 1'b0;
        jump_flag_o  = 1'b0;
        jump_addr_o  = 32'd0;
        busy_o       = 1'b0;
        if (rst) begin
            busy_o = (r_state != ST_IDLE);
            if (w_redirect) begin
                jump_flag_o  = 1'b1;
                jump_addr_o  = int_assert_i ? int_addr_i : jump_addr_i;
                hold_flag_o  = c_HOLD_ID;
                flush_idex_o = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = c_FLUSH_INIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            end else begin
                case (r_state)
                    ST_FLUSH: begin
                        hold_flag_o  = c_HOLD_ID;
                        flush_idex_o = 1'b1;
                        if (r_cnt <= 3'd1) begin
                            w_state_nxt = ST_IDLE;
                            w_cnt_nxt   = 3'd0;
                        end else begin
                            w_cnt_nxt = r_cnt - 3'd1;
                        end
                    end
                    ST_LDSTALL: begin
                        flush_idex_o = 1'b1;
                        if (w_hold_req) begin
                            hold_flag_o = c_HOLD_ID;
                        end else begin
                            hold_flag_o = c_HOLD_IF;
                            if (r_cnt <= 3'd1) begin
                                w_state_nxt = ST_IDLE;
                                w_cnt_nxt   = 3'd0;
                            end else begin
                                w_cnt_nxt = r_cnt - 3'd1;
                            end
                        end
                    end
                    default: begin
                        if (w_hold_req) begin
                            hold_flag_o = c_HOLD_ID;
                        end else if (load_use_i) begin
                            hold_flag_o  = c_HOLD_IF;
                            flush_idex_o = 1'b1;
                            if (LOAD_STALL_CYCLES > 1) begin
                                w_state_nxt = ST_LDSTALL;
                                w_cnt_nxt   = c_LDSTL_INIT;
                            end
                        end
                    end
                endcase
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_flush <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (flush_idex_o && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
            if ((hold_flag_o != c_HOLD_NONE) && !flush_idex_o &&
                (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_flush_cnt_o = r_perf_flush;
    assign perf_stall_cnt_o = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Self-checking bench for pipe_hazard_ctrl (two parameter sets).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag, int_assert, hold_ex, hold_bus, load_use;
    logic [31:0] jump_addr, int_addr;

    logic [2:0]  hold_a, hold_b;
    logic        flush_a, flush_b, jf_a, jf_b, busy_a, busy_b;
    logic [31:0] ja_a, ja_b;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] pf_a, ps_a, pf_b, ps_b;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .int_assert_i(int_assert), .int_addr_i(int_addr),
        .hold_ex_i(hold_ex), .hold_bus_i(hold_bus), .load_use_i(load_use),
        .hold_flag_o(hold_a), .flush_idex_o(flush_a),
        .jump_flag_o(jf_a), .jump_addr_o(ja_a), .busy_o(busy_a)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_flush_cnt_o(pf_a), .perf_stall_cnt_o(ps_a)
`endif
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag), .jump_addr_i(jump_addr),
        .int_assert_i(int_assert), .int_addr_i(int_addr),
        .hold_ex_i(hold_ex), .hold_bus_i(hold_bus), .load_use_i(load_use),
        .hold_flag_o(hold_b), .flush_idex_o(flush_b),
        .jump_flag_o(jf_b), .jump_addr_o(ja_b), .busy_o(busy_b)
`ifdef PIPE_HAZARD_PERF_EN
        , .perf_flush_cnt_o(pf_b), .perf_stall_cnt_o(ps_b)
`endif
    );

    logic [75:0] obs;
    assign obs = {hold_a, flush_a, jf_a, ja_a, busy_a,
                  hold_b, flush_b, jf_b, ja_b, busy_b};

    // Reference model: remaining flush / stall cycles per instance.
    int     flush_len [2] = '{2, 3};
    int     stall_len [2] = '{1, 3};
    int     flush_rem [2] = '{0, 0};
    int     stall_rem [2] = '{0, 0};
    longint perf_fl   [2] = '{0, 0};
    longint perf_st   [2] = '{0, 0};

    function automatic logic [37:0] model_out(input int k);
        logic [2:0]  h = 3'd0;
        logic        f = 1'b0;
        logic        j = 1'b0;
        logic        b = 1'b0;
        logic [31:0] a = 32'd0;
        if (rst) begin
            b = (flush_rem[k] > 0) || (stall_rem[k] > 0);
            if (int_assert || jump_flag) begin
                j = 1'b1;
                a = int_assert ? int_addr : jump_addr;
                h = 3'd3;
                f = 1'b1;
            end else if (flush_rem[k] > 0) begin
                h = 3'd3;
                f = 1'b1;
            end else if (stall_rem[k] > 0) begin
                f = 1'b1;
                h = (hold_ex || hold_bus) ? 3'd3 : 3'd2;
            end else if (hold_ex || hold_bus) begin
                h = 3'd3;
            end else if (load_use) begin
                h = 3'd2;
                f = 1'b1;
            end
        end
        return {h, f, j, a, b};
    endfunction

    function automatic logic [75:0] model_both();
        return {model_out(0), model_out(1)};
    endfunction

    task automatic model_step();
        logic [37:0] o;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                flush_rem[k] = 0;
                stall_rem[k] = 0;
                perf_fl[k]   = 0;
                perf_st[k]   = 0;
            end else begin
                o = model_out(k);
                if (o[34] && perf_fl[k] < 64'hFFFF_FFFF) perf_fl[k]++;
                if (o[37:35] != 3'd0 && !o[34] && perf_st[k] < 64'hFFFF_FFFF) perf_st[k]++;
                if (int_assert || jump_flag) begin
                    flush_rem[k] = flush_len[k] - 1;
                    stall_rem[k] = 0;
                end else if (flush_rem[k] > 0) begin
                    flush_rem[k]--;
                end else if (stall_rem[k] > 0) begin
                    if (!(hold_ex || hold_bus)) stall_rem[k]--;
                end else if (!(hold_ex || hold_bus) && load_use) begin
                    stall_rem[k] = stall_len[k] - 1;
                end
            end
        end
    endtask

    // v = {rst, jump_flag, int_assert, hold_ex, hold_bus, load_use}
    task automatic apply(input logic [5:0] v);
        {rst, jump_flag, int_assert, hold_ex, hold_bus, load_use} = v;
    endtask

    task automatic finish_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] seq [5] = '{6'b011111, 6'b011111, 6'b011111, 6'b100000, 6'b100000};
        jump_addr = 32'hFFFF_FFFF;
        int_addr  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            apply(seq[i]);
            @(negedge clk);
            nvec++;
            if (obs !== model_both()) begin
                nerr++;
                $display("FAIL reset step%0d: got %h required %h", i, obs, model_both());
            end
            nvec++;
            if ({busy_a, busy_b, hold_a, hold_b} !== 8'd0) begin
                nerr++;
                $display("FAIL reset_zero step%0d: got %b required 0", i, {busy_a, busy_b, hold_a, hold_b});
            end
            finish_cycle();
        end
    endtask

    task automatic test_redirect();
        logic [5:0] seq [8] = '{6'b110000, 6'b100000, 6'b100000, 6'b100000,
                                6'b111000, 6'b100000, 6'b100000, 6'b100000};
        jump_addr = 32'h0000_0100;
        int_addr  = 32'h0000_0008;
        for (int i = 0; i < 8; i++) begin
            apply(seq[i]);
            @(negedge clk);
            nvec++;
            if (obs !== model_both()) begin
                nerr++;
                $display("FAIL redirect step%0d: got %h required %h", i, obs, model_both());
            end
            if (i == 0 || i == 4) begin
                nvec++;
                if (ja_a !== ((i == 0) ? 32'h100 : 32'h8) || jf_a !== 1'b1) begin
                    nerr++;
                    $display("FAIL redirect_addr step%0d: got %h/%b required %h/1", i, ja_a, jf_a,
                             (i == 0) ? 32'h100 : 32'h8);
                end
            end
            finish_cycle();
        end
    endtask

    task automatic test_load_use();
        logic [5:0] seq [5] = '{6'b100001, 6'b100000, 6'b100000, 6'b100000, 6'b100000};
        for (int i = 0; i < 5; i++) begin
            apply(seq[i]);
            @(negedge clk);
            nvec++;
            if (obs !== model_both()) begin
                nerr++;
                $display("FAIL load_use step%0d: got %h required %h", i, obs, model_both());
            end
            finish_cycle();
        end
    endtask

    task automatic test_hold();
        logic [5:0] seq [12] = '{6'b100101, 6'b100101, 6'b100101, 6'b100101, 6'b100101,
                                 6'b100001, 6'b100000, 6'b100010, 6'b100000, 6'b100000,
                                 6'b100000, 6'b100000};
        for (int i = 0; i < 12; i++) begin
            apply(seq[i]);
            @(negedge clk);
            nvec++;
            if (obs !== model_both()) begin
                nerr++;
                $display("FAIL hold step%0d: got %h required %h", i, obs, model_both());
            end
            finish_cycle();
        end
    endtask

    task automatic test_flush_reset();
        logic [5:0] seq [9] = '{6'b110000, 6'b000000, 6'b100000, 6'b110000, 6'b110000,
                                6'b100000, 6'b100000, 6'b100000, 6'b100000};
        jump_addr = 32'h0000_0200;
        for (int i = 0; i < 9; i++) begin
            apply(seq[i]);
            @(negedge clk);
            nvec++;
            if (obs !== model_both()) begin
                nerr++;
                $display("FAIL flush_reset step%0d: got %h required %h", i, obs, model_both());
            end
            finish_cycle();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 49) != 0);
            jump_flag  = ($urandom_range(0, 6) == 0);
            int_assert = ($urandom_range(0, 12) == 0);
            hold_ex    = ($urandom_range(0, 4) == 0);
            hold_bus   = ($urandom_range(0, 8) == 0);
            load_use   = ($urandom_range(0, 2) == 0);
            jump_addr  = $urandom;
            int_addr   = $urandom;
            @(negedge clk);
            nvec++;
            if (obs !== model_both()) begin
                nerr++;
                $display("FAIL random cyc%0d: got %h required %h", i, obs, model_both());
            end
`ifdef PIPE_HAZARD_PERF_EN
            nvec++;
            if ({pf_a, ps_a, pf_b, ps_b} !== {perf_fl[0][31:0], perf_st[0][31:0],
                                              perf_fl[1][31:0], perf_st[1][31:0]}) begin
                nerr++;
                $display("FAIL perf cyc%0d: got %h %h %h %h required %h %h %h %h", i,
                         pf_a, ps_a, pf_b, ps_b, perf_fl[0][31:0], perf_st[0][31:0],
                         perf_fl[1][31:0], perf_st[1][31:0]);
            end
`endif
            finish_cycle();
        end
    endtask

    initial begin
        apply(6'b000000);
        jump_addr = 32'd0;
        int_addr  = 32'd0;
        test_reset();
        test_redirect();
        test_load_use();
        test_hold();
        test_flush_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline control block that produces the hold and flush requests consumed by the IF/ID and ID/EX pipeline registers.
It arbitrates four sources: redirects (jump/branch from EX, interrupt entry from CLINT), multi-cycle EX holds (mul/div), bus-arbiter holds, and load-use hazards from ID.
It owns the multi-cycle bubble sequencing, so the pipeline registers only ever see a single-cycle level per cycle.
It sits beside ex/clint/rib and drives hold_flag_o to every pipeline register plus the PC redirect to pc_reg.

Parameters:
FLUSH_CYCLES, 2, number of consecutive cycles ID/EX is forced to NOP after an accepted redirect (legal range 1..7).
LOAD_STALL_CYCLES, 1, number of cycles PC and IF/ID are held on a load-use hazard (legal range 1..3).

Ports:
clk  in  1  core clock.
rst  in  1  synchronous reset, active-low.
jump_flag_i  in  1  EX requests a redirect this cycle.
jump_addr_i  in  32  EX redirect target.
int_assert_i  in  1  CLINT interrupt entry/mret redirect.
int_addr_i  in  32  CLINT redirect target.
hold_ex_i  in  1  EX multi-cycle op busy.
hold_bus_i  in  1  bus arbiter stalls the core.
load_use_i  in  1  ID instruction reads rd of the load currently in EX.
hold_flag_o  out  3  0=Hold_None, 1=Hold_Pc, 2=Hold_If, 3=Hold_Id.
flush_idex_o  out  1  ID/EX loads INST_NOP / zeros this cycle.
jump_flag_o  out  1  redirect PC this cycle.
jump_addr_o  out  32  PC redirect target.
busy_o  out  1  FSM not in IDLE.

Behaviour:
Reset:
- rst sampled low at a rising edge sets state=IDLE, cnt=0, addr_q=0.
- While rst is low, every output is forced to 0, including the combinational paths.

Priority of requests within one cycle: int_assert_i > jump_flag_i > (hold_ex_i | hold_bus_i) > load_use_i.

Redirect:
- Same cycle (combinational): jump_flag_o=1; jump_addr_o = int_addr_i if int_assert_i, else jump_addr_i; hold_flag_o=3; flush_idex_o=1.
- Next edge: if FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; otherwise go to IDLE.
- A redirect is accepted in every state and always restarts FLUSH, so a later request overrides any in-progress sequence.

FLUSH:
- Outputs: hold_flag_o=3, flush_idex_o=1, jump_flag_o=0, busy_o=1.
- cnt decrements each cycle; when cnt reaches 1, return to IDLE at the next edge.
- hold_ex_i, hold_bus_i and load_use_i are ignored in FLUSH; EX holds NOP there, so these requests are spurious.

Hold (IDLE, no redirect, hold_ex_i|hold_bus_i):
- hold_flag_o=3, flush_idex_o=0, all registers frozen. Purely combinational; no state change.

Load-use (IDLE, no higher request, load_use_i):
- Same cycle: hold_flag_o=2, flush_idex_o=1 (a bubble enters EX while PC and IF/ID hold).
- If LOAD_STALL_CYCLES>1, enter LDSTALL with cnt=LOAD_STALL_CYCLES-1.

LDSTALL:
- Outputs: hold_flag_o=2, flush_idex_o=1, busy_o=1.
- cnt decrements; at cnt==1, return to IDLE.
- A redirect preempts LDSTALL (goes to FLUSH).
- hold_ex_i or hold_bus_i in LDSTALL raises hold_flag_o to 3 and freezes cnt.

IDLE with no request: all outputs 0.

Widths and registering:
- cnt is 3 bits.
- jump_addr_o is 0 whenever jump_flag_o=0.
- hold_flag_o is glitch-free with respect to state: it is decoded from the registered state ORed with same-cycle requests, taking the maximum level.

Optional Feature:
Macro: PIPE_HAZARD_PERF_EN.
With the macro defined:
- Adds outputs perf_flush_cnt_o[31:0] and perf_stall_cnt_o[31:0].
- perf_flush_cnt_o increments on each cycle with flush_idex_o=1.
- perf_stall_cnt_o increments on each cycle with hold_flag_o!=0 and flush_idex_o=0.
- Both counters saturate at 0xFFFFFFFF and are cleared by reset.
Without the macro: the ports and counters do not exist, and the core behaviour is identical.

Test Plan:
1. Reset with all inputs high, then release; inputs idle → all outputs 0, busy_o=0.
2. jump_flag_i=1, jump_addr_i=0x0000_0100 for 1 cycle (FLUSH_CYCLES=2) → cycle0: jump_flag_o=1, addr=0x100, hold=3, flush=1; cycle1: hold=3, flush=1, jump_flag_o=0; cycle2: all 0.
3. Same-cycle int_assert_i (int_addr_i=0x8) and jump_flag_i (0x100) → jump_addr_o=0x8, followed by the FLUSH sequence.
4. load_use_i for 1 cycle (LOAD_STALL_CYCLES=1) → hold=2, flush=1 for exactly 1 cycle, then 0; repeat with LOAD_STALL_CYCLES=3 → 3 cycles.
5. hold_ex_i high 5 cycles with load_use_i also high → hold=3, flush=0 for 5 cycles; then 1 cycle of hold=2, flush=1.
6. rst asserted in the middle of FLUSH, then jump_flag_i during the second FLUSH cycle → reset case: outputs 0 and IDLE after the edge; jump case: FLUSH restarts with 2 full cycles. With PIPE_HAZARD_PERF_EN, check the counters match the cycle counts above.
